// File: rtl/inst_mem.sv
// Instruction memory: word RAM with combinational fetch and a byte-serial,
// little-endian program-load port. Optional checksum under INST_MEM_CKSUM_EN.
module inst_mem #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  output logic        cpu_rst_o,
  output logic        ld_done_o,
`ifdef INST_MEM_CKSUM_EN
  output logic        ld_ovf_o,
  output logic [31:0] cksum_o
`else
  output logic        ld_ovf_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_ptr;
  logic [31:0]         shift_reg;
  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                word_end;
  logic                word_wr;
  logic [31:0]         word_data;
  logic [ADDR_W-1:0]   fetch_idx;
  logic                fetch_oor;
  logic                unused_addr_bits;

  assign accept    = (state == LOAD) && ld_valid_i && ld_ready_o;
  assign word_end  = (byte_cnt == 2'd3) || ld_last_i;
  // A reset in the same cycle as a completing byte discards that word too.
  assign word_wr   = accept && word_end && !rst;
  assign word_data = shift_reg | (32'(ld_byte_i) << {byte_cnt, 3'b000});

  assign fetch_idx        = inst_addr_i[ADDR_W+1:2];
  assign fetch_oor        = (inst_addr_i >> (ADDR_W + 2)) != 32'd0;
  assign unused_addr_bits = ^inst_addr_i[1:0];

  always_comb begin
    inst_o = mem[fetch_idx];
    if (state != IDLE || fetch_oor) inst_o = NOP_INST;
  end

  // NOTE: the storage array has no reset; a program image must survive rst,
  // and a reset loop over every word would not map onto RAM macros.
  always_ff @(posedge clk) begin
    if (word_wr) mem[word_ptr] <= word_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_ready_o <= 1'b0;
      cpu_rst_o  <= 1'b0;
      ld_done_o  <= 1'b0;
      ld_ovf_o   <= 1'b0;
      byte_cnt   <= 2'd0;
      word_ptr   <= '0;
      shift_reg  <= 32'd0;
`ifdef INST_MEM_CKSUM_EN
      cksum_o    <= 32'd0;
`endif
    end else begin
      ld_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start_i) begin
            state      <= LOAD;
            ld_ready_o <= 1'b1;
            cpu_rst_o  <= 1'b1;
            ld_ovf_o   <= 1'b0;
            byte_cnt   <= 2'd0;
            word_ptr   <= '0;
            shift_reg  <= 32'd0;
`ifdef INST_MEM_CKSUM_EN
            cksum_o    <= 32'd0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_end) begin
              byte_cnt  <= 2'd0;
              shift_reg <= 32'd0;
              word_ptr  <= word_ptr + ADDR_W'(1);
              if (&word_ptr) ld_ovf_o <= 1'b1;
`ifdef INST_MEM_CKSUM_EN
              cksum_o   <= cksum_o ^ word_data;
`endif
            end else begin
              byte_cnt  <= byte_cnt + 2'd1;
              shift_reg <= word_data;
            end
            if (ld_last_i) begin
              state      <= DONE;
              ld_ready_o <= 1'b0;
              ld_done_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          cpu_rst_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ld_ready_o <= 1'b0;
          cpu_rst_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
